// File: rtl/game_pkg.sv
// Shared types and constants for the pac-man game controller: FSM states,
// movement directions and the key-to-direction priority decode.
package game_pkg;

  localparam int GRID_SIZE = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PLAY   = 2'd1,
    ST_CAUGHT = 2'd2,
    ST_OVER   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'd0,
    DIR_LEFT  = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_UP    = 2'd3
  } dir_t;

  // Key bits are [3] up, [2] down, [1] left, [0] right; higher bit wins.
  function automatic dir_t key_to_dir(input logic [3:0] key);
    if (key[3])      return DIR_UP;
    else if (key[2]) return DIR_DOWN;
    else if (key[1]) return DIR_LEFT;
    else             return DIR_RIGHT;
  endfunction

endpackage

// File: rtl/tick_counter.sv
// Free-running 0..DIV-1 counter that advances only while enabled; tick marks
// the terminal count of an enabled cycle.
module tick_counter #(
  parameter int DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] count;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge values regardless of block ordering.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + W'(1);
    end
  end

  assign tick = en && (count == LAST);

endmodule

// File: rtl/game_ctrl.sv
// Game controller: paces pac-man and ghost movers, detects catches, runs the
// respawn sequence and keeps lives, score and the latched direction.
module game_ctrl
  import game_pkg::*;
#(
  parameter int PAC_DIV   = 25000000,
  parameter int GHOST_DIV = 50000000,
  parameter int LIVES     = 3,
  parameter int RESPAWN   = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic [3:0] i_key,
  input  logic [5:0] i_pac_x,
  input  logic [5:0] i_pac_y,
  input  logic [5:0] i_ghost_x,
  input  logic [5:0] i_ghost_y,
  output logic       o_pac_step,
  output logic [1:0] o_dir,
  output logic       o_ghost_step,
  output logic       o_mover_rst_n,
  output logic [1:0] o_state,
  output logic [1:0] o_lives,
  output logic [7:0] o_score,
  output logic       o_caught
);

  localparam int RW = (RESPAWN > 1) ? $clog2(RESPAWN) : 1;
  localparam logic [RW-1:0] RESP_LAST = RW'(RESPAWN - 1);

  state_t        state, state_nxt;
  dir_t          dir;
  logic [RW-1:0] resp_cnt;
  logic          pac_tick, ghost_tick;
  logic          pending, step_d;
  logic          play, start_go, resp_done, cnt_clr, collide;

  assign play      = (state == ST_PLAY);
  assign start_go  = ((state == ST_IDLE) || (state == ST_OVER)) && i_start;
  assign resp_done = (state == ST_CAUGHT) && (resp_cnt == RESP_LAST);
  assign cnt_clr   = start_go || resp_done;

  // Movers need one cycle to present the new position after a step.
  assign collide = play && !step_d &&
                   (i_pac_x == i_ghost_x) && (i_pac_y == i_ghost_y);

  tick_counter #(.DIV(PAC_DIV)) u_pac_div (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .en      (play),
    .clr     (cnt_clr),
    .tick    (pac_tick)
  );

  tick_counter #(.DIV(GHOST_DIV)) u_ghost_div (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .en      (play),
    .clr     (cnt_clr),
    .tick    (ghost_tick)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_OVER: if (i_start) state_nxt = ST_PLAY;
      ST_PLAY:          if (collide) state_nxt = ST_CAUGHT;
      ST_CAUGHT:        if (resp_done) state_nxt = (o_lives == 2'd0) ? ST_OVER : ST_PLAY;
      default:          state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    o_pac_step    = 1'b0;
    o_ghost_step  = 1'b0;
    o_caught      = 1'b0;
    o_mover_rst_n = 1'b0;
    case (state)
      ST_PLAY: begin
        o_mover_rst_n = 1'b1;
        if (collide) begin
          o_caught = 1'b1;
        end else begin
          o_pac_step   = pac_tick;
          o_ghost_step = pending || (ghost_tick && !pac_tick);
        end
      end
      ST_OVER: o_mover_rst_n = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dir      <= DIR_RIGHT;
      o_lives  <= 2'd0;
      o_score  <= 8'd0;
      resp_cnt <= '0;
      pending  <= 1'b0;
      step_d   <= 1'b0;
    end else begin
      if (i_key != 4'd0) dir <= key_to_dir(i_key);

      step_d <= o_pac_step || o_ghost_step;

      // A ghost step colliding with a pac step is deferred by one cycle.
      if (cnt_clr)                       pending <= 1'b0;
      else if (o_pac_step && ghost_tick) pending <= 1'b1;
      else if (o_ghost_step)             pending <= 1'b0;

      if (state == ST_CAUGHT && !resp_done) resp_cnt <= resp_cnt + RW'(1);
      else                                  resp_cnt <= '0;

      if (start_go)     o_lives <= 2'(LIVES);
      else if (collide) o_lives <= o_lives - 2'd1;

      if (start_go)                             o_score <= 8'd0;
      else if (o_pac_step && o_score != 8'hFF)  o_score <= o_score + 8'd1;
    end
  end

  assign o_dir   = dir;
  assign o_state = state;

endmodule

// File: tb/tb_game_ctrl.sv
// Self-checking bench for game_ctrl: key table, directed game sequences and a
// randomized run against a play-cycle-index reference model.
module tb_game_ctrl;

  localparam int P = 4;
  localparam int G = 8;
  localparam int L = 3;
  localparam int R = 4;

  logic       i_clk = 1'b0;
  logic       i_rst_n, i_start;
  logic [3:0] i_key;
  logic [5:0] i_pac_x, i_pac_y, i_ghost_x, i_ghost_y;
  logic       o_pac_step, o_ghost_step, o_mover_rst_n, o_caught;
  logic [1:0] o_dir, o_state, o_lives;
  logic [7:0] o_score;

  game_ctrl #(.PAC_DIV(P), .GHOST_DIV(G), .LIVES(L), .RESPAWN(R)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_start       (i_start),
    .i_key         (i_key),
    .i_pac_x       (i_pac_x),
    .i_pac_y       (i_pac_y),
    .i_ghost_x     (i_ghost_x),
    .i_ghost_y     (i_ghost_y),
    .o_pac_step    (o_pac_step),
    .o_dir         (o_dir),
    .o_ghost_step  (o_ghost_step),
    .o_mover_rst_n (o_mover_rst_n),
    .o_state       (o_state),
    .o_lives       (o_lives),
    .o_score       (o_score),
    .o_caught      (o_caught)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: state 0 idle, 1 play, 2 caught, 3 over. m_k counts PLAY
  // cycles completed since the last entry into PLAY.
  int m_state, m_k, m_lives, m_score, m_dir, m_resp;
  bit m_prev_step;
  bit e_pac, e_ghost, e_caught, e_mrst;
  logic s_pac, s_ghost, s_caught, s_mrst;
  logic [1:0] s_state;

  task automatic model_reset();
    m_state = 0; m_k = 0; m_lives = 0; m_score = 0; m_dir = 0; m_resp = 0;
    m_prev_step = 0;
  endtask

  function automatic bit due(input int k, input int d);
    return (k > 0) && (k % d == 0);
  endfunction

  task automatic model_expect();
    int k;
    e_pac = 0; e_ghost = 0; e_caught = 0;
    e_mrst = (m_state == 1) || (m_state == 3);
    if (m_state == 1) begin
      k = m_k + 1;
      if (!m_prev_step && i_pac_x == i_ghost_x && i_pac_y == i_ghost_y) begin
        e_caught = 1;
      end else begin
        e_pac   = due(k, P);
        e_ghost = (due(k, G) && !due(k, P)) || (due(k - 1, G) && due(k - 1, P));
      end
    end
  endtask

  task automatic model_update();
    if (!i_rst_n) begin
      model_reset();
      return;
    end
    if (i_key != 4'd0) m_dir = i_key[3] ? 3 : i_key[2] ? 2 : i_key[1] ? 1 : 0;
    case (m_state)
      0, 3: if (i_start) begin
        m_state = 1; m_lives = L; m_score = 0; m_k = 0; m_prev_step = 0;
      end
      1: begin
        if (e_caught) begin
          m_lives--; m_state = 2; m_resp = 0; m_prev_step = 0;
        end else begin
          if (e_pac && m_score < 255) m_score++;
          m_k++;
          m_prev_step = e_pac || e_ghost;
        end
      end
      default: begin
        m_resp++;
        if (m_resp == R) begin
          m_state = (m_lives == 0) ? 3 : 1; m_k = 0; m_prev_step = 0;
        end
      end
    endcase
  endtask

  task automatic tick(input logic st, input logic [3:0] key,
                      input logic [5:0] px, input logic [5:0] py,
                      input logic [5:0] gx, input logic [5:0] gy);
    @(negedge i_clk);
    i_start = st; i_key = key;
    i_pac_x = px; i_pac_y = py; i_ghost_x = gx; i_ghost_y = gy;
    #1;
    model_expect();
    s_pac = o_pac_step; s_ghost = o_ghost_step; s_caught = o_caught;
    s_mrst = o_mover_rst_n; s_state = o_state;
    check("state",      o_state,       m_state);
    check("lives",      o_lives,       m_lives);
    check("score",      o_score,       m_score);
    check("dir",        o_dir,         m_dir);
    check("pac_step",   o_pac_step,    e_pac);
    check("ghost_step", o_ghost_step,  e_ghost);
    check("caught",     o_caught,      e_caught);
    check("mover_rst",  o_mover_rst_n, e_mrst);
    check("step_excl",  o_pac_step & o_ghost_step, 0);
    @(posedge i_clk);
    model_update();
  endtask

  task automatic tick_d(input logic st, input logic [3:0] key);
    tick(st, key, 6'd10, 6'd10, 6'd20, 6'd20);
  endtask

  task automatic tick_s(input logic st, input logic [3:0] key);
    tick(st, key, 6'd10, 6'd10, 6'd10, 6'd10);
  endtask

  task automatic catch_one(input string name);
    int budget = 12;
    do begin
      tick_s(0, 4'd0);
      budget--;
    end while (!s_caught && budget > 0);
    check(name, s_caught, 1);
  endtask

  typedef struct {
    logic [3:0] key;
    logic [1:0] exp_dir;
  } key_vec_t;

  key_vec_t kv[11];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_low, n_pulse, n_steps;
    bit over_seen;
    logic [5:0] px, py, gx, gy;

    kv[0]  = '{4'b0001, 2'd0};  kv[1]  = '{4'b0010, 2'd1};
    kv[2]  = '{4'b0100, 2'd2};  kv[3]  = '{4'b1000, 2'd3};
    kv[4]  = '{4'b0000, 2'd3};  kv[5]  = '{4'b0110, 2'd2};
    kv[6]  = '{4'b0011, 2'd1};  kv[7]  = '{4'b0000, 2'd1};
    kv[8]  = '{4'b1111, 2'd3};  kv[9]  = '{4'b1010, 2'd3};
    kv[10] = '{4'b0001, 2'd0};

    i_rst_n = 1'b0; i_start = 1'b0; i_key = 4'd0;
    i_pac_x = 6'd10; i_pac_y = 6'd10; i_ghost_x = 6'd20; i_ghost_y = 6'd20;
    model_reset();

    // Reset state, including a key press that must not latch while in reset.
    tick_d(0, 4'd0);
    tick_d(1, 4'b1000);
    #2;
    check("rst_state", o_state, 0);
    check("rst_dir", o_dir, 0);
    check("rst_lives", o_lives, 0);
    check("rst_score", o_score, 0);
    check("rst_mover", o_mover_rst_n, 0);
    i_rst_n = 1'b1;

    // Direction latching from a table, while idle.
    for (int i = 0; i < 11; i++) begin
      tick_d(0, kv[i].key);
      #2;
      check("key_dir", o_dir, kv[i].exp_dir);
    end

    tick_d(1, 4'd0);
    #2;
    check("start_state", o_state, 1);
    check("start_lives", o_lives, 3);
    check("start_score", o_score, 0);
    check("start_mover", o_mover_rst_n, 1);

    for (int c = 1; c <= 12; c++) begin
      tick_d(0, 4'd0);
      check("pac_cycle", s_pac, (c % 4 == 0));
      check("ghost_cycle", s_ghost, (c == 9));
    end
    #2;
    check("score_after_12", o_score, 3);

    tick_d(0, 4'b1010);
    #2;
    check("dir_up", o_dir, 3);
    repeat (10) tick_d(0, 4'd0);
    #2;
    check("dir_hold", o_dir, 3);
    tick_d(0, 4'b0001);
    #2;
    check("dir_right", o_dir, 0);

    // First catch and respawn.
    catch_one("catch1_seen");
    n_low = 0; n_pulse = 0;
    for (int i = 0; i < R; i++) begin
      tick_d(0, 4'd0);
      if (!s_mrst && s_state == 2'd2) n_low++;
      if (s_caught) n_pulse++;
    end
    check("respawn_low_cycles", n_low, R);
    check("caught_single_pulse", n_pulse, 0);
    #2;
    check("lives_after_catch1", o_lives, 2);
    check("back_to_play", o_state, 1);
    check("mover_released", o_mover_rst_n, 1);

    // Remaining catches lead to game over.
    over_seen = 0;
    for (int i = 0; i < 60 && !over_seen; i++) begin
      tick_s(0, 4'd0);
      #2;
      over_seen = (o_state == 2'd3);
    end
    check("game_over", o_state, 3);
    check("over_lives", o_lives, 0);
    n_steps = 0;
    repeat (20) begin
      tick_d(0, 4'b0100);
      if (s_pac || s_ghost) n_steps++;
    end
    check("over_no_steps", n_steps, 0);
    tick_d(1, 4'd0);
    #2;
    check("restart_state", o_state, 1);
    check("restart_lives", o_lives, 3);
    check("restart_score", o_score, 0);

    // Reset during the second CAUGHT cycle.
    catch_one("catch_for_reset");
    tick_s(0, 4'd0);
    @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    check("mid_caught_rst_state", o_state, 0);
    check("mid_caught_rst_lives", o_lives, 0);
    check("mid_caught_rst_mover", o_mover_rst_n, 0);
    model_reset();
    tick_d(0, 4'd0);
    #2 i_rst_n = 1'b1;

    // Restart after reset, then run long enough to saturate the score.
    tick_d(1, 4'd0);
    repeat (1100) tick_d(0, 4'd0);
    #2;
    check("score_saturated", o_score, 255);

    // Randomized play against the model.
    repeat (3000) begin
      px = 6'($urandom_range(0, 3));
      py = 6'($urandom_range(0, 1));
      gx = ($urandom_range(0, 2) == 0) ? px : 6'($urandom_range(0, 3));
      gy = ($urandom_range(0, 2) == 0) ? py : 6'($urandom_range(0, 1));
      tick(($urandom_range(0, 19) == 0),
           ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0,
           px, py, gx, gy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 SHALL have parameter PAC_DIV, default 25000000, clock cycles between pac-man step enables.
REQ-002 SHALL have parameter GHOST_DIV, default 50000000, clock cycles between ghost step enables.
REQ-003 SHALL have parameter LIVES, default 3, lives loaded on game start (range 1..3).
REQ-004 SHALL have parameter RESPAWN, default 4, cycles o_mover_rst_n is held low after a catch.
REQ-005 SHALL have port i_clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-006 SHALL have port i_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port i_start, input, 1 bit: one-cycle start pulse.
REQ-008 SHALL have port i_key, input, 4 bits: debounced key pulses; [3] up, [2] down, [1] left, [0] right.
REQ-009 SHALL have ports i_pac_x and i_pac_y, input, 6 bits each: pac-man position from the mover.
REQ-010 SHALL have ports i_ghost_x and i_ghost_y, input, 6 bits each: ghost position from the mover.
REQ-011 SHALL have port o_pac_step, output, 1 bit: one-cycle pac-man move enable.
REQ-012 SHALL have port o_dir, output, 2 bits: latched direction; 0 right, 1 left, 2 down, 3 up.
REQ-013 SHALL have port o_ghost_step, output, 1 bit: one-cycle ghost move enable.
REQ-014 SHALL have port o_mover_rst_n, output, 1 bit: active-low reset to both movers.
REQ-015 SHALL have port o_state, output, 2 bits: 0 IDLE, 1 PLAY, 2 CAUGHT, 3 OVER.
REQ-016 SHALL have ports o_lives (2 bits), o_score (8 bits) and o_caught (1-bit pulse), all outputs.

Function
REQ-017 SHALL move IDLE->PLAY, or OVER->PLAY, on i_start; on that transition lives=LIVES, score=0, both tick counters=0, and the pending-ghost flag is cleared.
REQ-018 SHALL, in PLAY, increment each tick counter every cycle, counting 0..DIV-1 and wrapping to 0; the first enable fires on the DIV-th cycle in PLAY.
REQ-019 SHALL freeze both tick counters outside PLAY.
REQ-020 SHALL pulse o_pac_step when the pac counter equals PAC_DIV-1.
REQ-021 SHALL pulse o_ghost_step when the ghost counter equals GHOST_DIV-1 and the pac counter does not.
REQ-022 SHALL, when both counters terminate in the same cycle, issue o_pac_step that cycle and o_ghost_step the next cycle via a pending flag; the two enables are never asserted together.
REQ-023 SHALL evaluate a collision (pac x,y == ghost x,y) only in PLAY cycles not immediately following a step pulse (settle cycle).
REQ-024 SHALL, on collision: suppress any step due that cycle; pulse o_caught for one cycle; decrement lives; go to CAUGHT.
REQ-025 SHALL hold o_mover_rst_n low for exactly RESPAWN cycles in CAUGHT, then go to OVER if lives==0, else to PLAY with counters cleared.
REQ-026 SHALL drive o_mover_rst_n low in IDLE and CAUGHT, and high in PLAY and OVER.
REQ-027 SHALL latch o_dir on any cycle where i_key != 0, priority up>down>left>right; with i_key==0, o_dir holds its value; keys are accepted in every state.
REQ-028 SHALL increment o_score on each o_pac_step, saturating at 255.
REQ-029 SHALL ignore i_start in PLAY and CAUGHT.

Reset
REQ-030 SHALL, on i_rst_n low, immediately set: state IDLE, o_dir=0, o_lives=0, o_score=0, all pulses 0, o_mover_rst_n=0, counters, respawn counter and pending flag 0.
REQ-031 SHALL abort any state (including mid-CAUGHT) on reset, with no pending step surviving it.

Structure
REQ-032 SHALL place the state enum, the direction enum and the grid-size constant (5) in shared package game_pkg.
REQ-033 SHALL implement each divider as sub-module tick_counter (parameter DIV; inputs en, clr; output tick), instantiated twice.

Verification (PAC_DIV=4, GHOST_DIV=8, LIVES=3, RESPAWN=4)
REQ-034 SHALL check: reset, then i_start -> next cycle o_state=1, o_lives=3, o_score=0, o_mover_rst_n=1.
REQ-035 SHALL check: PLAY with positions distinct -> o_pac_step on PLAY cycles 4, 8, 12; o_ghost_step on cycle 9 only (deferred); o_score=3 after cycle 12.
REQ-036 SHALL check: i_key=4'b1010 -> o_dir=3; i_key=0 for 10 cycles -> o_dir stays 3; i_key=4'b0001 -> o_dir=0.
REQ-037 SHALL check: force ghost position = pac position -> one o_caught pulse, o_lives 3->2, o_mover_rst_n low for 4 cycles, then o_state=1.
REQ-038 SHALL check: third catch -> o_state=3, no step pulses for 20 cycles; i_start -> o_state=1, o_lives=3, o_score=0.
REQ-039 SHALL check: i_rst_n low during the second CAUGHT cycle -> same cycle o_state=0, o_lives=0, o_mover_rst_n=0.
